// File: rtl/ex_stage.sv
// ex_stage -- execute stage of the five-stage MIPS pipeline.
//
// Takes the decoded controls and operands from the ID/EX register, computes
// the ALU result, resolves branch/jump redirection and registers everything
// into the EX/MEM boundary.
//
// Build option: define EX_ITERATIVE_MUL_EN to build the 32-step shift-add
// multiplier for ALU code 1000. Without it, code 1000 returns 0 in one cycle
// and oStall is tied low.
//
// Ports:
//   clock, reset          pipeline clock, asynchronous active-high reset
//   iFlush                squash the instruction in EX (from registered oPCSrc)
//   iRegWrite..iJumps     decoded controls
//   iALUCtrl              ALU operation code
//   iA, iB, isignext      rs value, rt value, sign-extended immediate
//   iBranch, iJump        precomputed branch / jump targets
//   iRegDest              destination register number
//   oRegWrite..oMemToReg  registered controls
//   oALUResult            registered ALU / multiply result
//   oStoreData, oRegDest  registered rt value and destination
//   oZero                 registered (A - Bop == 0)
//   oPCSrc, oTarget       registered redirect request and target
//   oStall                combinational upstream hold (ID/EX enable = ~oStall)
module ex_stage #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             iFlush,
    input  logic             iRegWrite,
    input  logic             iALUSrc,
    input  logic             iMemRead,
    input  logic             iMemWrite,
    input  logic             iMemToReg,
    input  logic             iBranchs,
    input  logic             iJumps,
    input  logic [3:0]       iALUCtrl,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic [WIDTH-1:0] isignext,
    input  logic [WIDTH-1:0] iBranch,
    input  logic [WIDTH-1:0] iJump,
    input  logic [4:0]       iRegDest,
    output logic             oRegWrite,
    output logic             oMemRead,
    output logic             oMemWrite,
    output logic             oMemToReg,
    output logic [WIDTH-1:0] oALUResult,
    output logic [WIDTH-1:0] oStoreData,
    output logic [4:0]       oRegDest,
    output logic             oZero,
    output logic             oPCSrc,
    output logic [WIDTH-1:0] oTarget,
    output logic             oStall
);

    if (WIDTH != 32 || MUL_CYCLES != 32) begin : g_bad_cfg
        $error("ex_stage: only WIDTH=32 and MUL_CYCLES=32 are supported");
    end

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_MUL = 4'b1000;

    logic [WIDTH-1:0] bop;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic             zero;
    logic             pcsrc;
    logic [WIDTH-1:0] target;
    logic             stall;

`ifdef EX_ITERATIVE_MUL_EN
    localparam int CNT_W = $clog2(MUL_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
`endif

    // ---------------- ALU and redirect ----------------
    always_comb begin
        bop     = iALUSrc ? isignext : iB;
        diff    = iA - bop;
        alu_res = '0;
        unique case (iALUCtrl)
            ALU_AND: alu_res = iA & bop;
            ALU_OR:  alu_res = iA | bop;
            ALU_ADD: alu_res = iA + bop;
            ALU_SUB: alu_res = diff;
            ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, $signed(iA) < $signed(bop)};
            ALU_NOR: alu_res = ~(iA | bop);
`ifdef EX_ITERATIVE_MUL_EN
            // Only consumed in DONE; earlier cycles load bubbles.
            ALU_MUL: alu_res = acc_q;
`else
            ALU_MUL: alu_res = '0;
`endif
            default: alu_res = '0;
        endcase
        zero = (diff == '0);

        pcsrc  = 1'b0;
        target = '0;
        if (iJumps) begin
            pcsrc  = 1'b1;
            target = iJump;
        end else if (iBranchs && zero) begin
            pcsrc  = 1'b1;
            target = iBranch;
        end
    end

`ifdef EX_ITERATIVE_MUL_EN
    // ---------------- Multiplier FSM ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        unique case (state_q)
            S_IDLE: begin
                if (iALUCtrl == ALU_MUL && !iFlush) begin
                    state_d  = S_BUSY;
                    mcand_d  = iA;
                    mplier_d = bop;
                    acc_d    = '0;
                    count_d  = '0;
                end
            end
            S_BUSY: begin
                if (iFlush) begin
                    state_d = S_IDLE;
                end else begin
                    if (mplier_q[0]) acc_d = acc_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + 1'b1;
                    if (count_q == LAST_CNT) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        stall = 1'b0;
        if (state_q == S_BUSY) stall = 1'b1;
        else if (state_q == S_IDLE && iALUCtrl == ALU_MUL && !iFlush) stall = 1'b1;
    end
`else
    always_comb stall = 1'b0;
`endif

    assign oStall = stall;

    // ---------------- EX/MEM register ----------------
    logic             regwrite_q, regwrite_d;
    logic             memread_q, memread_d;
    logic             memwrite_q, memwrite_d;
    logic             memtoreg_q, memtoreg_d;
    logic [WIDTH-1:0] alu_q, alu_d;
    logic [WIDTH-1:0] store_q, store_d;
    logic [4:0]       dest_q, dest_d;
    logic             zero_q, zero_d;
    logic             pcsrc_q, pcsrc_d;
    logic [WIDTH-1:0] target_q, target_d;

    always_comb begin
        regwrite_d = 1'b0;
        memread_d  = 1'b0;
        memwrite_d = 1'b0;
        memtoreg_d = 1'b0;
        alu_d      = '0;
        store_d    = '0;
        dest_d     = '0;
        zero_d     = 1'b0;
        pcsrc_d    = 1'b0;
        target_d   = '0;
        if (!(iFlush || stall)) begin
            regwrite_d = iRegWrite;
            memread_d  = iMemRead;
            memwrite_d = iMemWrite;
            memtoreg_d = iMemToReg;
            alu_d      = alu_res;
            store_d    = iB;
            dest_d     = iRegDest;
            zero_d     = zero;
            pcsrc_d    = pcsrc;
            target_d   = target;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            alu_q      <= '0;
            store_q    <= '0;
            dest_q     <= '0;
            zero_q     <= 1'b0;
            pcsrc_q    <= 1'b0;
            target_q   <= '0;
        end else begin
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            memtoreg_q <= memtoreg_d;
            alu_q      <= alu_d;
            store_q    <= store_d;
            dest_q     <= dest_d;
            zero_q     <= zero_d;
            pcsrc_q    <= pcsrc_d;
            target_q   <= target_d;
        end
    end

    assign oRegWrite  = regwrite_q;
    assign oMemRead   = memread_q;
    assign oMemWrite  = memwrite_q;
    assign oMemToReg  = memtoreg_q;
    assign oALUResult = alu_q;
    assign oStoreData = store_q;
    assign oRegDest   = dest_q;
    assign oZero      = zero_q;
    assign oPCSrc     = pcsrc_q;
    assign oTarget    = target_q;

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage MIPS pipeline, sitting directly downstream of the ID/EX pipeline register. It consumes the decoded controls and operands, computes the ALU result, resolves branch and jump redirection, and registers everything into the EX/MEM boundary. An optional iterative 32-cycle multiplier stalls the upstream stages through a stall output that drives the ID/EX register's enable, inverted.

## Interface
Parameters:
- WIDTH, 32, datapath width; only 32 is supported.
- MUL_CYCLES, 32, shift-add iterations per multiply; only 32 is supported.

Ports:
- clock  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- iFlush  in  1  squash the instruction currently in EX; driven by the registered oPCSrc.
- iRegWrite, iALUSrc, iMemRead, iMemWrite, iMemToReg, iBranchs, iJumps  in  1 each  decoded controls.
- iALUCtrl  in  4  ALU operation code.
- iA, iB, isignext  in  32 each  rs value, rt value, sign-extended immediate.
- iBranch, iJump  in  32 each  precomputed branch target and jump target.
- iRegDest  in  5  destination register number.
- oRegWrite, oMemRead, oMemWrite, oMemToReg  out  1 each  registered controls.
- oALUResult  out  32  registered ALU or multiply result.
- oStoreData  out  32  registered iB.
- oRegDest  out  5  registered destination.
- oZero  out  1  registered (A − Bop == 0).
- oPCSrc  out  1  registered redirect request.
- oTarget  out  32  registered redirect target.
- oStall  out  1  combinational; when high, upstream holds (ID/EX enable = ~oStall).

## Operation
- Operand selection: Bop = iALUSrc ? isignext : iB.
- ALU codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 0 or 1), 1100 NOR.
  - 1000 MUL (see Configuration).
  - Any other code returns 0.
- ADD and SUB wrap modulo 2^32; no overflow trap.
- Redirect:
  - iJumps=1 → PCSrc=1, Target=iJump. This takes priority over branch.
  - Otherwise iBranchs=1 and zero → PCSrc=1, Target=iBranch.
  - Otherwise PCSrc=0, Target=0.
- Bubble: all control outputs (oRegWrite, oMemRead, oMemWrite, oMemToReg, oPCSrc) are 0. oALUResult, oStoreData, oRegDest, oTarget and oZero are also 0.
- EX/MEM register loads:
  - A bubble when iFlush=1 or oStall=1.
  - Otherwise the computed values.
- Multiplier FSM (present only with the macro):
  - IDLE: if iALUCtrl=1000 and iFlush=0, assert oStall. On the edge, latch multiplicand=iA and multiplier=Bop, clear the accumulator, set count=0, and go to BUSY.
  - BUSY: assert oStall. Each edge performs one step: if the multiplier LSB=1, accumulator += multiplicand; then multiplicand <<= 1 and multiplier >>= 1; count++. After the step with count=31, go to DONE.
  - DONE: oStall=0. EX/MEM captures oALUResult = accumulator (low 32 bits, identical for signed and unsigned) together with the held ID/EX controls. The next edge goes to IDLE.
  - iFlush=1 in any state: go to IDLE and load a bubble; the multiply is abandoned.

## Timing
- Non-MUL instructions: single cycle, with results on the EX/MEM outputs one edge after the ID/EX outputs present them.
- MUL: oStall is high for 33 cycles (the IDLE-detect cycle plus 32 BUSY cycles). The result is registered on the edge that ends the DONE cycle, so the multiply occupies EX for 34 cycles in total.
- During a stall, 33 bubbles enter EX/MEM.
- Back-to-back MUL: the second MUL is detected in IDLE on the cycle after DONE, with no extra gap.
- Reset (asynchronous, including mid-multiply):
  - All outputs go to 0; oStall=0 once reset is released with no MUL present.
  - FSM returns to IDLE; count, accumulator and operand registers clear to 0.
- iFlush and a stall in the same cycle: flush wins, and oStall drops in the next cycle.

## Configuration
- EX_ITERATIVE_MUL_EN defined: the multiplier FSM, its registers and the stall path are built, and code 1000 behaves as above.
- Not defined: there is no FSM, oStall is tied 0, and code 1000 returns 0 in a single cycle like any unsupported code.

## Test plan
- ADD with iA=5, iB=7, iALUSrc=0 → next edge oALUResult=12, oRegWrite follows iRegWrite. SLT with iA=0xFFFFFFFF, Bop=1 → 1.
- BEQ with iBranchs=1, iA=iB=0x10, iBranch=0x40 → oPCSrc=1, oTarget=0x40. The same inputs with iJumps=1 and iJump=0x80 → oTarget=0x80.
- MUL with iA=6, iB=7 (macro on) → oStall high for exactly 33 cycles, 33 bubbles, then oALUResult=42. A MUL of 0xFFFFFFFF×2 → 0xFFFFFFFE.
- Reset asserted at BUSY count 10 → outputs 0 immediately. After reset, a fresh MUL of 3×3 → 9 after the full 33-cycle stall.
- iFlush=1 during BUSY → oStall low next cycle and bubble captured. With the macro off, MUL → oStall never rises and oALUResult=0.
